instr_fetch_unit: RTL and testbench

//  Producer side of the opcode/control interface: fetches 32-bit MIPS words from instruction

---
 rtl/instr_fetch_unit.sv | 190 +++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: keeps the fetch PC, issues one read at a time to
// instruction memory, buffers returned words in a small prefetch queue and
// presents the queue head to the decode stage. A taken branch/jump redirects
// fetch, flushes the queue and discards any read issued on the wrong path.
//
// Handshakes:
//   imem: imem_req/imem_addr are registered and held stable until the cycle
//         imem_ack is high; that cycle carries imem_rdata for the request.
//   decode: the head entry transfers on a rising edge where
//           instr_valid & instr_ready; instr_valid never depends on
//           instr_ready, and head outputs come straight from queue registers.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2   // 2 or 4 (pointers wrap as powers of two)
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [31:0] instr_pc,
  output logic [31:0] pcplus4,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int            PW = $clog2(QDEPTH);
  localparam int            CW = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0] QD = CW'(QDEPTH);

  // IDLE: no read outstanding. REQ: read outstanding on the correct path.
  // DROP: read outstanding whose data belongs to a path already abandoned.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t        state, state_next;
  logic          req_next;
  logic [31:0]   addr_next;
  logic [31:0]   fpc, fpc_next;

  logic [31:0]   q_word [QDEPTH];
  logic [31:0]   q_pc   [QDEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;

  logic          push, pop, slot_free;
  logic [31:0]   redirect_addr;
  logic          unused_redirect_bits;

  // Targets are word aligned; the low two bits of redirect_pc carry no meaning.
  assign redirect_addr        = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_bits = ^redirect_pc[1:0];

  // Only an ack for a correct-path read fills the queue, and a redirect in the
  // same cycle makes even that read stale.
  assign push = imem_ack & (state == REQ) & ~redirect;
  // A redirect flushes the queue, so a consume in that cycle has no effect.
  assign pop  = instr_valid & instr_ready & ~redirect;

  // Occupancy after this edge; also decides whether another read may be issued.
  always_comb begin
    count_next = count;
    if (redirect) begin
      count_next = '0;
    end else if (push && !pop) begin
      count_next = count + CW'(1);
    end else if (!push && pop) begin
      count_next = count - CW'(1);
    end
  end

  // A new read is only issued when its data is guaranteed a queue slot.
  assign slot_free = (count_next < QD);

  // Prefetch queue storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_word[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else begin
      count <= count_next;
      if (redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          q_word[wr_ptr] <= imem_rdata;
          q_pc[wr_ptr]   <= imem_addr;
          wr_ptr         <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
      end
    end
  end

  // Head of queue drives decode directly from registers.
  assign instr_valid = (count != '0);
  assign instr       = q_word[rd_ptr];
  assign op          = instr[31:26];
  assign instr_pc    = q_pc[rd_ptr];
  assign pcplus4     = instr_pc + 32'd4;

  // Fetch control: next state, request, address and fetch PC.
  always_comb begin
    state_next = state;
    req_next   = imem_req;
    addr_next  = imem_addr;
    fpc_next   = fpc;
    case (state)
      IDLE: begin
        if (redirect) begin
          // New target is latched now; the read goes out on the next cycle.
          fpc_next = redirect_addr;
          req_next = 1'b0;
        end else if (slot_free) begin
          req_next   = 1'b1;
          addr_next  = fpc;
          state_next = REQ;
        end else begin
          req_next = 1'b0;
        end
      end
      REQ: begin
        if (redirect) begin
          fpc_next = redirect_addr;
          if (imem_ack) begin
            // Read just completed on the old path: drop it, start the new one.
            addr_next = redirect_addr;
          end else begin
            // Read still in flight: must wait for its ack before reissuing.
            state_next = DROP;
          end
        end else if (imem_ack) begin
          fpc_next = fpc + 32'd4;
          if (slot_free) begin
            addr_next = fpc + 32'd4;
          end else begin
            req_next   = 1'b0;
            state_next = IDLE;
          end
        end
      end
      DROP: begin
        if (redirect) begin
          fpc_next = redirect_addr;
        end
        if (imem_ack) begin
          // Queue was flushed by the redirect, so a slot is always free here.
          addr_next  = fpc_next;
          state_next = REQ;
        end
      end
      default: begin
        state_next = IDLE;
        req_next   = 1'b0;
      end
    endcase
  end

  // Fetch control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      fpc       <= RESET_PC;
    end else begin
      state     <= state_next;
      imem_req  <= req_next;
      imem_addr <= addr_next;
      fpc       <= fpc_next;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [31:0] instr_pc;
  logic [31:0] pcplus4;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  // second instance exercising the top-of-memory wrap
  logic        w_reset = 1'b1;
  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic        w_imem_ack = 1'b0;
  logic [31:0] w_imem_rdata = '0;
  logic        w_instr_valid;
  logic [31:0] w_instr;
  logic [5:0]  w_op;
  logic [31:0] w_instr_pc;
  logic [31:0] w_pcplus4;
  logic        w_instr_ready = 1'b0;
  logic        w_redirect = 1'b0;
  logic [31:0] w_redirect_pc = '0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) u_dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .op(op),
    .instr_pc(instr_pc), .pcplus4(pcplus4), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .QDEPTH(2)) u_wrap (
    .clk(clk), .reset(w_reset),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_ack(w_imem_ack), .imem_rdata(w_imem_rdata),
    .instr_valid(w_instr_valid), .instr(w_instr), .op(w_op),
    .instr_pc(w_instr_pc), .pcplus4(w_pcplus4), .instr_ready(w_instr_ready),
    .redirect(w_redirect), .redirect_pc(w_redirect_pc)
  );

  // ---------------- bookkeeping ----------------
  int n_assert = 0;
  int n_fail   = 0;
  int n_push   = 0;
  int n_req    = 0;
  int wcnt     = 0;
  int mem_wait = 0;
  int base     = 0;
  logic        force_ack  = 1'b0;
  logic        prev_req   = 1'b0;
  logic        prev_ack   = 1'b0;
  logic        wrong_path = 1'b0;
  logic [31:0] prev_addr  = '0;
  logic [31:0] last_req_addr = '0;

  // scoreboard: {pc, word} of every instruction decode should see, in order
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // memory contents: opcode varies with address, low half is the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [5:0] o;
    o = a[7:2] + 6'h23;
    return {o, 10'h001, a[15:0]};
  endfunction

  // ---------------- driver: one clock cycle ----------------
  // Called at a negedge with the cycle's inputs already set; acts as memory,
  // updates the reference model, then advances to the next negedge.
  task automatic tick();
    logic [63:0] e;
    logic        do_ack;
    if (!reset) begin
      check("valid_vs_model", {31'b0, instr_valid}, {31'b0, (exp_q.size() != 0)});
      if (prev_req && !prev_ack) begin
        check("req_hold", {31'b0, imem_req}, 32'd1);
        check("addr_hold", imem_addr, prev_addr);
      end
      if (imem_req && !(prev_req && !prev_ack)) begin
        n_req++;
        last_req_addr = imem_addr;
        check("req_align", {30'b0, imem_addr[1:0]}, 32'd0);
      end
    end
    do_ack = 1'b0;
    if (force_ack) begin
      do_ack = 1'b1;
      wcnt   = 0;
    end else if (imem_req === 1'b1) begin
      if (wcnt >= mem_wait) begin
        do_ack = 1'b1;
        wcnt   = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
    if (reset) begin
      exp_q.delete();
      wrong_path = 1'b0;
    end else begin
      if (instr_valid && instr_ready && !redirect && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("head_pc", instr_pc, e[63:32]);
        check("head_word", instr, e[31:0]);
        check("head_op", {26'b0, op}, {26'b0, e[31:26]});
        check("head_pcplus4", pcplus4, e[63:32] + 32'd4);
      end
      if (redirect) begin
        exp_q.delete();
        wrong_path = imem_req && !do_ack;
      end else if (do_ack && imem_req) begin
        if (wrong_path) begin
          wrong_path = 1'b0;
        end else begin
          exp_q.push_back({imem_addr, mem_word(imem_addr)});
          n_push++;
        end
      end
    end
    imem_ack   = do_ack;
    imem_rdata = do_ack ? mem_word(imem_addr) : $urandom;
    prev_req   = reset ? 1'b0 : imem_req;
    prev_ack   = do_ack;
    prev_addr  = imem_addr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    @(negedge clk);
    tick();
    tick();
    // reset values
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_op", {26'b0, op}, 32'd0);
    check("rst_pc", instr_pc, 32'd0);
    check("rst_pcplus4", pcplus4, 32'd4);

    // 1: streaming fetch, zero-wait memory, decode always ready
    instr_ready = 1'b1;
    mem_wait    = 0;
    reset       = 1'b0;
    tick();
    check("t1_req_latency", {31'b0, imem_req}, 32'd1);
    check("t1_addr0", imem_addr, 32'h0);
    tick();
    check("t1_valid_latency", {31'b0, instr_valid}, 32'd1);
    check("t1_op_first", {26'b0, op}, 32'b100011);
    check("t1_addr4", imem_addr, 32'h4);
    tick();
    check("t1_addr8", imem_addr, 32'h8);
    tick();
    check("t1_addrC", imem_addr, 32'hC);
    for (int i = 0; i < 6; i++) tick();

    // 2: decode stalled, queue fills to depth and fetch stops
    instr_ready = 1'b0;
    do_reset();
    base = n_push;
    for (int i = 0; i < 6; i++) tick();
    check("t2_push_count", n_push - base, 32'd2);
    check("t2_req_low", {31'b0, imem_req}, 32'd0);
    check("t2_head_pc", instr_pc, 32'h0);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("t2_refetch_req", {31'b0, imem_req}, 32'd1);
    check("t2_refetch_addr", imem_addr, 32'h8);
    check("t2_head_after_pop", instr_pc, 32'h4);
    tick();
    tick();
    check("t2_req_low_again", {31'b0, imem_req}, 32'd0);
    check("t2_push_total", n_push - base, 32'd3);

    // 3: redirect while a slow read to 0x10 is outstanding
    instr_ready = 1'b1;
    mem_wait    = 3;
    do_reset();
    for (int i = 0; i < 60 && !(imem_req && imem_addr == 32'h10); i++) tick();
    check("t3_reach_0x10", {31'b0, (imem_req && imem_addr == 32'h10)}, 32'd1);
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect    = 1'b0;
    base = n_req;
    for (int i = 0; i < 20 && n_req == base; i++) tick();
    check("t3_next_addr", last_req_addr, 32'h40);
    for (int i = 0; i < 20 && !instr_valid; i++) tick();
    check("t3_first_pc", instr_pc, 32'h40);

    // 4: redirect to an unaligned target in the same cycle as an ack
    instr_ready = 1'b0;
    mem_wait    = 2;
    do_reset();
    for (int i = 0; i < 30 && !(exp_q.size() == 1 && imem_req && wcnt >= mem_wait); i++) tick();
    check("t4_setup", {31'b0, (exp_q.size() == 1 && imem_req && wcnt >= mem_wait)}, 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h83;
    tick();
    redirect    = 1'b0;
    check("t4_flushed", {31'b0, instr_valid}, 32'd0);
    check("t4_req", {31'b0, imem_req}, 32'd1);
    check("t4_addr", imem_addr, 32'h80);
    instr_ready = 1'b1;
    for (int i = 0; i < 20 && !instr_valid; i++) tick();
    check("t4_first_pc", instr_pc, 32'h80);
    check("t4_first_word", instr, mem_word(32'h80));

    // 7: redirect from idle with full queue: new instruction three cycles later
    instr_ready = 1'b0;
    mem_wait    = 0;
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    check("t7_idle", {31'b0, imem_req}, 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h500;
    tick();
    redirect    = 1'b0;
    check("t7_r1_valid", {31'b0, instr_valid}, 32'd0);
    check("t7_r1_req", {31'b0, imem_req}, 32'd0);
    tick();
    check("t7_r2_req", {31'b0, imem_req}, 32'd1);
    check("t7_r2_addr", imem_addr, 32'h500);
    tick();
    check("t7_r3_valid", {31'b0, instr_valid}, 32'd1);
    check("t7_r3_pc", instr_pc, 32'h500);

    // 8: back-to-back redirects, last one wins
    instr_ready = 1'b1;
    mem_wait    = 4;
    do_reset();
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect_pc = 32'h300;
    tick();
    redirect    = 1'b0;
    base = n_req;
    for (int i = 0; i < 20 && n_req == base; i++) tick();
    check("t8_last_wins", last_req_addr, 32'h300);
    for (int i = 0; i < 20 && !instr_valid; i++) tick();
    check("t8_first_pc", instr_pc, 32'h300);

    // 5: fetch PC wraps past the top of memory
    w_reset = 1'b0;
    tick();
    check("t5_req", {31'b0, w_imem_req}, 32'd1);
    check("t5_addr_top", w_imem_addr, 32'hFFFF_FFFC);
    w_imem_ack   = 1'b1;
    w_imem_rdata = mem_word(32'hFFFF_FFFC);
    tick();
    w_imem_ack   = 1'b0;
    check("t5_addr_wrap", w_imem_addr, 32'h0);
    check("t5_valid", {31'b0, w_instr_valid}, 32'd1);
    check("t5_pc", w_instr_pc, 32'hFFFF_FFFC);
    check("t5_pcplus4_wrap", w_pcplus4, 32'h0);
    check("t5_word", w_instr, mem_word(32'hFFFF_FFFC));
    check("t5_op", {26'b0, w_op}, {26'b0, mem_word(32'hFFFF_FFFC) >> 26});

    // 6: reset with a read outstanding, ack lands during and just after reset
    instr_ready = 1'b1;
    mem_wait    = 5;
    do_reset();
    tick();
    tick();
    check("t6_outstanding", {31'b0, imem_req}, 32'd1);
    reset     = 1'b1;
    force_ack = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    force_ack = 1'b0;
    check("t6_no_valid", {31'b0, instr_valid}, 32'd0);
    check("t6_restart_req", {31'b0, imem_req}, 32'd1);
    check("t6_restart_addr", imem_addr, 32'h0);
    mem_wait = 0;
    tick();
    check("t6_first_valid", {31'b0, instr_valid}, 32'd1);
    check("t6_first_pc", instr_pc, 32'h0);

    // random traffic: stalls, memory waits and redirects, scoreboard checked
    do_reset();
    for (int i = 0; i < 300; i++) begin
      instr_ready = 1'($urandom_range(0, 1));
      mem_wait    = $urandom_range(0, 2);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom_range(0, 1023);
      tick();
    end
    redirect    = 1'b0;
    instr_ready = 1'b1;
    mem_wait    = 0;
    for (int i = 0; i < 10; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // watchdog: the directed sequence is bounded, this only guards a stuck run
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
